// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg: state encoding, mode codes and timing constants shared by the rx sync controller
package rx_ctrl_pkg;
  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_SD    = 6'b000010,
    S_PD    = 6'b000100,
    S_BD    = 6'b001000,
    S_RUN   = 6'b010000,
    S_FLUSH = 6'b100000
  } state_t;
  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;
  localparam int SD_DEBOUNCE   = 4;
  localparam int FLUSH_CC      = 2;
  localparam int BD_WINDOW_MAX = 30;
  function automatic logic [3:0] mode_fix(input logic [3:0] m);
    return (m == MODE_BPSK || m == MODE_QPSK || m == MODE_MIX) ? m : MODE_BPSK;
  endfunction
endpackage

// File: rtl/rx_timeout_cnt.sv
// rx_timeout_cnt: per-state dwell counter; expire is high on the cycle where count reaches limit-1 (limit 0 disables)
module rx_timeout_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign expire = en && limit != '0 && cnt == limit - 1'b1;
endmodule

// File: rtl/rx_sync_ctrl.sv
// rx_sync_ctrl: receiver acquisition sequencer (signal, phase, boundary detect) with frame run/flush control
// FRAME_CNT_INIT presets the frame counter at reset as a bring-up aid; leave it 0 in normal use.
module rx_sync_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int          MAX_WINDOW_WIDTH = 8,
  parameter int          TIMEOUT_WIDTH    = 16,
  parameter logic [15:0] FRAME_CNT_INIT   = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_en,
  input  logic [3:0]                  cfg_mode,
  input  logic [MAX_WINDOW_WIDTH-1:0] cfg_bd_window,
  input  logic [TIMEOUT_WIDTH-1:0]    cfg_pd_timeout,
  input  logic [TIMEOUT_WIDTH-1:0]    cfg_bd_timeout,
  input  logic                        energy_det,
  input  logic                        pll_locked,
  input  logic                        corr_peak,
  input  logic                        corr_sgn,
  input  logic                        disassert_BD,
  input  logic                        disassert_PD,
  output logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
  output logic [3:0]                  MODE_CTRL,
  output logic                        SD_flag,
  output logic                        PD_flag,
  output logic                        BD_flag,
  output logic                        BD_sgn,
  output logic                        busy,
  output logic                        err_timeout,
  output logic [15:0]                 frame_cnt
);
  state_t st, nx;
  logic [2:0] deb;
  logic [1:0] fc;
  logic expire, to_err;
  logic [TIMEOUT_WIDTH-1:0] limit;
  assign limit = st == S_PD ? cfg_pd_timeout : cfg_bd_timeout;
  rx_timeout_cnt #(.W(TIMEOUT_WIDTH)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (nx != st),
    .en     (st == S_PD || st == S_BD),
    .limit  (limit),
    .expire (expire)
  );
  // a timeout only counts as an error when it is what actually moves the state
  always_comb begin
    nx = st;
    to_err = 1'b0;
    case (st)
      S_IDLE: nx = cfg_en ? S_SD : S_IDLE;
      S_SD: nx = !cfg_en ? S_IDLE : (energy_det && deb == 3'(SD_DEBOUNCE - 1)) ? S_PD : S_SD;
      S_PD: begin
        nx = !cfg_en ? S_IDLE : !energy_det ? S_SD : pll_locked ? S_BD : expire ? S_SD : S_PD;
        to_err = cfg_en && energy_det && !pll_locked && expire;
      end
      S_BD: begin
        nx = !cfg_en ? S_IDLE : corr_peak ? S_RUN : expire ? S_SD : S_BD;
        to_err = cfg_en && !corr_peak && expire;
      end
      S_RUN: nx = (disassert_BD || disassert_PD) ? S_FLUSH : S_RUN;
      S_FLUSH: nx = fc != 2'(FLUSH_CC - 1) ? S_FLUSH : !cfg_en ? S_IDLE :
                    (energy_det && pll_locked) ? S_BD : S_SD;
      default: nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= S_IDLE;
      deb <= '0;
      fc <= '0;
      SD_flag <= 1'b0;
      PD_flag <= 1'b0;
      BD_flag <= 1'b0;
      BD_sgn <= 1'b0;
      busy <= 1'b0;
      err_timeout <= 1'b0;
      MODE_CTRL <= MODE_BPSK;
      RX_BD_WINDOW <= MAX_WINDOW_WIDTH'(1);
      frame_cnt <= FRAME_CNT_INIT;
    end else begin
      st <= nx;
      deb <= (st == S_SD && nx == S_SD && energy_det) ? deb + 3'd1 : '0;
      fc <= (st == S_FLUSH && nx == S_FLUSH) ? fc + 2'd1 : '0;
      SD_flag <= nx inside {S_PD, S_BD, S_RUN};
      PD_flag <= nx inside {S_BD, S_RUN};
      BD_flag <= nx == S_RUN && st != S_RUN;
      busy <= nx != S_IDLE;
      err_timeout <= to_err;
      if (st == S_BD && nx == S_RUN)
        BD_sgn <= corr_sgn;
      if (st == S_RUN && nx == S_FLUSH && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (st == S_IDLE && nx == S_SD) begin
        MODE_CTRL <= mode_fix(cfg_mode);
        RX_BD_WINDOW <= cfg_bd_window == '0 ? MAX_WINDOW_WIDTH'(1) :
                        cfg_bd_window > MAX_WINDOW_WIDTH'(BD_WINDOW_MAX) ? MAX_WINDOW_WIDTH'(BD_WINDOW_MAX) :
                        cfg_bd_window;
      end
    end
  end
endmodule
